// File: rtl/sd_wb_host_regs.sv
// sd_wb_host_regs: Wishbone slave register file for the SD host controller.
// Holds the command/argument/timeout/clock/interrupt-enable registers, arbitrates
// command loads between the bus and the internal requester, and packs writes to
// the RX/TX buffer-descriptor windows into MEM_WIDTH-wide beats.
// Optional feature macro: SD_WB_ERR_EN (adds wb_err_o for unmapped/RO-write accesses).
module sd_wb_host_regs #(
    parameter int          MEM_WIDTH     = 32,
    parameter logic [7:0]  RESET_CLK_DIV = 8'h02,
    parameter logic [15:0] BLOCK_SIZE    = 16'd512
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [7:0]           wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic                 wb_ack_o,
`ifdef SD_WB_ERR_EN
    output logic                 wb_err_o,
`endif
    input  logic                 write_req_s,
    input  logic [15:0]          cmd_set_s,
    input  logic [31:0]          cmd_arg_s,
    output logic                 we_ack,
    output logic                 cmd_int_busy,
    output logic                 new_cmd,
    output logic                 int_busy,
    output logic [31:0]          argument_reg,
    output logic [15:0]          cmd_setting_reg,
    input  logic [15:0]          status_reg,
    input  logic [31:0]          cmd_resp_1,
    output logic [7:0]           software_reset_reg,
    output logic [15:0]          time_out_reg,
    input  logic [15:0]          normal_int_status_reg,
    input  logic [15:0]          error_int_status_reg,
    output logic [15:0]          normal_int_signal_enable_reg,
    output logic [15:0]          error_int_signal_enable_reg,
    output logic                 normal_isr_reset,
    output logic                 error_isr_reset,
    output logic                 bd_isr_reset,
    output logic [7:0]           clock_divider,
    input  logic [15:0]          bd_status_reg,
    input  logic [7:0]           bd_isr_reg,
    output logic [7:0]           bd_isr_enable_reg,
    output logic                 bd_rx_we,
    output logic                 bd_tx_we,
    output logic [MEM_WIDTH-1:0] bd_dat_o,
    input  logic                 bd_rx_full,
    input  logic                 bd_tx_full
);

    localparam int         BEATS     = 32 / MEM_WIDTH;
    localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_BD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic        bd_tx_q, bd_tx_d;
    logic        err_q, err_d;

    logic [31:0] arg_q, arg_d;
    logic [15:0] cmd_q, cmd_d;
    logic [7:0]  swrst_q, swrst_d;
    logic [15:0] tout_q, tout_d;
    logic [15:0] niser_q, niser_d;
    logic [15:0] eiser_q, eiser_d;
    logic [7:0]  clkdiv_q, clkdiv_d;
    logic [7:0]  bdiser_q, bdiser_d;
    logic [31:0] rdat_q, rdat_d;
    logic        new_cmd_q, new_cmd_d;
    logic        we_ack_q, we_ack_d;
    logic        cib_q, cib_d;
    logic        busy_q, busy_d;
    logic        nclr_q, nclr_d;
    logic        eclr_q, eclr_d;
    logic        bclr_q, bclr_d;

    logic        bus_req;
    logic        is_bd_adr;
    logic        busy_set;
    logic [31:0] be_mask;
    logic [31:0] rd_mux;
    logic        adr_mapped;
    logic        adr_ro;
    int          bd_shamt;
    logic [31:0] bd_shift;

    // Byte-enable merge: keep old bytes where the strobe is low.
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign bus_req   = wb_cyc_i & wb_stb_i;
    assign is_bd_adr = (wb_adr_i == 8'h60) || (wb_adr_i == 8'h80);
    assign be_mask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign bd_shamt  = int'(beat_q) * MEM_WIDTH;
    assign bd_shift  = wb_dat_i >> bd_shamt;

    // Read multiplexer and address classification (mapped / read-only).
    always_comb begin
        rd_mux     = 32'h0;
        adr_mapped = 1'b1;
        adr_ro     = 1'b0;
        case (wb_adr_i)
            8'h00: rd_mux = arg_q;
            8'h04: rd_mux = {16'h0, cmd_q};
            8'h08: begin rd_mux = {16'h0, status_reg}; adr_ro = 1'b1; end
            8'h0C: begin rd_mux = cmd_resp_1;          adr_ro = 1'b1; end
            8'h1C: adr_ro = 1'b1;
            8'h20: begin rd_mux = {16'h0, BLOCK_SIZE}; adr_ro = 1'b1; end
            8'h24: begin rd_mux = 32'h0000_000F;       adr_ro = 1'b1; end
            8'h28: rd_mux = {24'h0, swrst_q};
            8'h2C: rd_mux = {16'h0, tout_q};
            8'h30: rd_mux = {16'h0, normal_int_status_reg};
            8'h34: rd_mux = {16'h0, error_int_status_reg};
            8'h38: rd_mux = {16'h0, niser_q};
            8'h3C: rd_mux = {16'h0, eiser_q};
            8'h48: adr_ro = 1'b1;
            8'h4C: rd_mux = {24'h0, clkdiv_q};
            8'h50: begin rd_mux = {16'h0, bd_status_reg}; adr_ro = 1'b1; end
            8'h54: rd_mux = {24'h0, bd_isr_reg};
            8'h58: rd_mux = {24'h0, bdiser_q};
            8'h60, 8'h80: rd_mux = 32'h0;
            default: adr_mapped = 1'b0;
        endcase
    end

    // Access FSM next state and descriptor beat generation.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        bd_tx_d  = bd_tx_q;
        err_d    = err_q;
        bd_rx_we = 1'b0;
        bd_tx_we = 1'b0;
        bd_dat_o = '0;
        case (state_q)
            S_IDLE: begin
                if (bus_req) begin
                    err_d = ~adr_mapped | (wb_we_i & adr_ro);
                    if (wb_we_i && is_bd_adr) begin
                        state_d = S_BD;
                        beat_d  = 2'd0;
                        bd_tx_d = (wb_adr_i == 8'h80);
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            S_BD: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else begin
                    bd_dat_o = bd_shift[MEM_WIDTH-1:0];
                    if (!(bd_tx_q ? bd_tx_full : bd_rx_full)) begin
                        bd_rx_we = ~bd_tx_q;
                        bd_tx_we = bd_tx_q;
                        if (beat_q == BEAT_LAST) begin
                            state_d = S_ACK;
                        end else begin
                            beat_d = beat_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register writes, command-request service, clear pulses and read capture.
    always_comb begin
        arg_d     = arg_q;
        cmd_d     = cmd_q;
        swrst_d   = swrst_q;
        tout_d    = tout_q;
        niser_d   = niser_q;
        eiser_d   = eiser_q;
        clkdiv_d  = clkdiv_q;
        bdiser_d  = bdiser_q;
        rdat_d    = rdat_q;
        new_cmd_d = 1'b0;
        we_ack_d  = 1'b0;
        cib_d     = 1'b0;
        nclr_d    = 1'b0;
        eclr_d    = 1'b0;
        bclr_d    = 1'b0;
        busy_set  = 1'b0;
        if (state_q == S_IDLE && bus_req) begin
            rdat_d = rd_mux;
            if (wb_we_i) begin
                case (wb_adr_i)
                    8'h00: begin arg_d = merge_be(arg_q, wb_dat_i, be_mask); new_cmd_d = 1'b1; end
                    8'h04: begin cmd_d = 16'(merge_be({16'h0, cmd_q}, wb_dat_i, be_mask)); busy_set = 1'b1; end
                    8'h28: swrst_d  = 8'(merge_be({24'h0, swrst_q}, wb_dat_i, be_mask));
                    8'h2C: tout_d   = 16'(merge_be({16'h0, tout_q}, wb_dat_i, be_mask));
                    8'h30: nclr_d   = 1'b1;
                    8'h34: eclr_d   = 1'b1;
                    8'h38: niser_d  = 16'(merge_be({16'h0, niser_q}, wb_dat_i, be_mask));
                    8'h3C: eiser_d  = 16'(merge_be({16'h0, eiser_q}, wb_dat_i, be_mask));
                    8'h4C: clkdiv_d = 8'(merge_be({24'h0, clkdiv_q}, wb_dat_i, be_mask));
                    8'h54: bclr_d   = 1'b1;
                    8'h58: bdiser_d = 8'(merge_be({24'h0, bdiser_q}, wb_dat_i, be_mask));
                    default: ;
                endcase
            end
        end else if (state_q == S_IDLE && write_req_s && !we_ack_q) begin
            // The requester holds write_req_s until it sees we_ack, so skip the
            // cycle in which we_ack is already high to avoid a double load.
            cmd_d     = cmd_set_s;
            arg_d     = cmd_arg_s;
            new_cmd_d = 1'b1;
            we_ack_d  = 1'b1;
            cib_d     = 1'b1;
        end
        busy_d = busy_set | (busy_q & ~status_reg[0]);
    end

    // State and register storage with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            beat_q    <= 2'd0;
            bd_tx_q   <= 1'b0;
            err_q     <= 1'b0;
            arg_q     <= 32'h0;
            cmd_q     <= 16'h0;
            swrst_q   <= 8'h0;
            tout_q    <= 16'h0;
            niser_q   <= 16'h0;
            eiser_q   <= 16'h0;
            clkdiv_q  <= RESET_CLK_DIV;
            bdiser_q  <= 8'h0;
            rdat_q    <= 32'h0;
            new_cmd_q <= 1'b0;
            we_ack_q  <= 1'b0;
            cib_q     <= 1'b0;
            busy_q    <= 1'b0;
            nclr_q    <= 1'b0;
            eclr_q    <= 1'b0;
            bclr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            bd_tx_q   <= bd_tx_d;
            err_q     <= err_d;
            arg_q     <= arg_d;
            cmd_q     <= cmd_d;
            swrst_q   <= swrst_d;
            tout_q    <= tout_d;
            niser_q   <= niser_d;
            eiser_q   <= eiser_d;
            clkdiv_q  <= clkdiv_d;
            bdiser_q  <= bdiser_d;
            rdat_q    <= rdat_d;
            new_cmd_q <= new_cmd_d;
            we_ack_q  <= we_ack_d;
            cib_q     <= cib_d;
            busy_q    <= busy_d;
            nclr_q    <= nclr_d;
            eclr_q    <= eclr_d;
            bclr_q    <= bclr_d;
        end
    end

`ifdef SD_WB_ERR_EN
    assign wb_ack_o = (state_q == S_ACK) & ~err_q;
    assign wb_err_o = (state_q == S_ACK) & err_q;
`else
    assign wb_ack_o = (state_q == S_ACK);
`endif

    assign wb_dat_o                     = rdat_q;
    assign we_ack                       = we_ack_q;
    assign cmd_int_busy                 = cib_q;
    assign new_cmd                      = new_cmd_q;
    assign int_busy                     = busy_q;
    assign argument_reg                 = arg_q;
    assign cmd_setting_reg              = cmd_q;
    assign software_reset_reg           = swrst_q;
    assign time_out_reg                 = tout_q;
    assign normal_int_signal_enable_reg = niser_q;
    assign error_int_signal_enable_reg  = eiser_q;
    assign normal_isr_reset             = nclr_q;
    assign error_isr_reset              = eclr_q;
    assign bd_isr_reset                 = bclr_q;
    assign clock_divider                = clkdiv_q;
    assign bd_isr_enable_reg            = bdiser_q;

endmodule

// File: tb/tb_sd_wb_host_regs.sv
// Directed testbench for sd_wb_host_regs with MEM_WIDTH=16.
module tb_sd_wb_host_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adr = 8'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic [3:0]  sel = 4'h0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        ack;
`ifdef SD_WB_ERR_EN
    logic        err;
`endif
    logic        write_req_s = 1'b0;
    logic [15:0] cmd_set_s = 16'h0;
    logic [31:0] cmd_arg_s = 32'h0;
    logic        we_ack, cmd_int_busy, new_cmd, int_busy;
    logic [31:0] argument_reg;
    logic [15:0] cmd_setting_reg;
    logic [15:0] status_reg = 16'h0;
    logic [7:0]  software_reset_reg;
    logic [15:0] time_out_reg;
    logic [15:0] nie, eie;
    logic        n_clr, e_clr, b_clr;
    logic [7:0]  clock_divider;
    logic [7:0]  bd_isr_enable_reg;
    logic        bd_rx_we, bd_tx_we;
    logic [15:0] bd_dat_o;
    logic        bd_rx_full = 1'b0, bd_tx_full = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    sd_wb_host_regs #(.MEM_WIDTH(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
`ifdef SD_WB_ERR_EN
        .wb_err_o(err),
`endif
        .write_req_s(write_req_s), .cmd_set_s(cmd_set_s), .cmd_arg_s(cmd_arg_s),
        .we_ack(we_ack), .cmd_int_busy(cmd_int_busy), .new_cmd(new_cmd), .int_busy(int_busy),
        .argument_reg(argument_reg), .cmd_setting_reg(cmd_setting_reg), .status_reg(status_reg),
        .cmd_resp_1(32'h1357_9BDF), .software_reset_reg(software_reset_reg),
        .time_out_reg(time_out_reg), .normal_int_status_reg(16'h0011),
        .error_int_status_reg(16'h0022), .normal_int_signal_enable_reg(nie),
        .error_int_signal_enable_reg(eie), .normal_isr_reset(n_clr), .error_isr_reset(e_clr),
        .bd_isr_reset(b_clr), .clock_divider(clock_divider), .bd_status_reg(16'h0033),
        .bd_isr_reg(8'h44), .bd_isr_enable_reg(bd_isr_enable_reg), .bd_rx_we(bd_rx_we),
        .bd_tx_we(bd_tx_we), .bd_dat_o(bd_dat_o), .bd_rx_full(bd_rx_full), .bd_tx_full(bd_tx_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_start(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic bus_stop();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        bus_start(a, d, s, 1'b1);
        tick();
        chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
        bus_stop();
        tick();
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d, input string tag);
        bus_start(a, 32'h0, 4'hF, 1'b0);
        tick();
        chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
        d = dat_o;
        bus_stop();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_clkdiv", {24'h0, clock_divider}, 32'h02);
        chk("rst_arg", argument_reg, 32'h0);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_busy", {31'h0, int_busy}, 32'h0);
        chk("rst_bddat", {16'h0, bd_dat_o}, 32'h0);
        rst = 1'b0;
        tick();

        // Read-only / reset-valued registers
        wb_read(8'h4C, rd, "rd_clk");   chk("rd_clk_val", rd, 32'h02);
        wb_read(8'h24, rd, "rd_pwr");   chk("rd_pwr_val", rd, 32'h0F);
        wb_read(8'h20, rd, "rd_blk");   chk("rd_blk_val", rd, 32'h200);
        wb_read(8'h0C, rd, "rd_resp");  chk("rd_resp_val", rd, 32'h1357_9BDF);
        wb_read(8'h54, rd, "rd_bdisr"); chk("rd_bdisr_val", rd, 32'h44);
        wb_read(8'h70, rd, "rd_unmap"); chk("rd_unmap_val", rd, 32'h0);

        // Argument write with partial byte enables, new_cmd pulse and ack timing
        bus_start(8'h00, 32'hAABB_CCDD, 4'b0101, 1'b1);
        tick();
        chk("arg_ack", {31'h0, ack}, 32'h1);
        chk("arg_newcmd", {31'h0, new_cmd}, 32'h1);
        chk("arg_reg", argument_reg, 32'h00BB_00DD);
        bus_stop();
        tick();
        chk("arg_ack_end", {31'h0, ack}, 32'h0);
        chk("arg_newcmd_end", {31'h0, new_cmd}, 32'h0);
        wb_read(8'h00, rd, "rd_arg"); chk("rd_arg_val", rd, 32'h00BB_00DD);

        // Clock divider: sel=0 write ignored, byte-0 write applied
        wb_write(8'h4C, 32'hFFFF_FFFF, 4'b0000, "clk_sel0");
        chk("clk_sel0_val", {24'h0, clock_divider}, 32'h02);
        wb_write(8'h4C, 32'hFFFF_FF05, 4'b0001, "clk_wr");
        chk("clk_wr_val", {24'h0, clock_divider}, 32'h05);

        // Clear pulse fires with sel=0
        bus_start(8'h30, 32'h0, 4'b0000, 1'b1);
        tick();
        chk("nclr_pulse", {31'h0, n_clr}, 32'h1);
        bus_stop();
        tick();
        chk("nclr_end", {31'h0, n_clr}, 32'h0);

        // Write to a read-only address
        bus_start(8'h08, 32'hFFFF_FFFF, 4'hF, 1'b1);
        tick();
`ifdef SD_WB_ERR_EN
        chk("ro_wr_ack", {31'h0, ack}, 32'h0);
        chk("ro_wr_err", {31'h0, err}, 32'h1);
`else
        chk("ro_wr_ack", {31'h0, ack}, 32'h1);
`endif
        bus_stop();
        tick();

        // RX descriptor write with back-pressure
        bd_rx_full = 1'b1;
        bus_start(8'h60, 32'h1234_5678, 4'hF, 1'b1);
        tick();
        chk("bd_full1_we", {31'h0, bd_rx_we}, 32'h0);
        tick();
        chk("bd_full2_we", {31'h0, bd_rx_we}, 32'h0);
        tick();
        chk("bd_full3_we", {31'h0, bd_rx_we}, 32'h0);
        chk("bd_full3_ack", {31'h0, ack}, 32'h0);
        tick();
        bd_rx_full = 1'b0;
        #1;
        chk("bd_b0_we", {31'h0, bd_rx_we}, 32'h1);
        chk("bd_b0_dat", {16'h0, bd_dat_o}, 32'h5678);
        chk("bd_b0_txwe", {31'h0, bd_tx_we}, 32'h0);
        tick();
        chk("bd_b1_we", {31'h0, bd_rx_we}, 32'h1);
        chk("bd_b1_dat", {16'h0, bd_dat_o}, 32'h1234);
        chk("bd_b1_ack", {31'h0, ack}, 32'h0);
        tick();
        chk("bd_ack", {31'h0, ack}, 32'h1);
        chk("bd_ack_we", {31'h0, bd_rx_we}, 32'h0);
        bus_stop();
        tick();
        chk("bd_ack_end", {31'h0, ack}, 32'h0);

        // Internal command request deferred behind a bus access
        write_req_s = 1'b1; cmd_set_s = 16'h0119; cmd_arg_s = 32'hDEAD_0000;
        bus_start(8'h08, 32'h0, 4'hF, 1'b0);
        tick();
        chk("req_defer_ack", {31'h0, we_ack}, 32'h0);
        chk("req_bus_ack", {31'h0, ack}, 32'h1);
        bus_stop();
        tick();
        chk("req_idle_ack", {31'h0, we_ack}, 32'h0);
        tick();
        chk("req_we_ack", {31'h0, we_ack}, 32'h1);
        chk("req_cib", {31'h0, cmd_int_busy}, 32'h1);
        chk("req_newcmd", {31'h0, new_cmd}, 32'h1);
        chk("req_cmd", {16'h0, cmd_setting_reg}, 32'h0119);
        chk("req_arg", argument_reg, 32'hDEAD_0000);
        write_req_s = 1'b0;
        tick();
        chk("req_we_ack_end", {31'h0, we_ack}, 32'h0);

        // Command write coinciding with completion: set wins, then clear
        status_reg = 16'h0001;
        bus_start(8'h04, 32'h0000_0001, 4'hF, 1'b1);
        tick();
        chk("busy_set", {31'h0, int_busy}, 32'h1);
        chk("busy_cmd", {16'h0, cmd_setting_reg}, 32'h0001);
        bus_stop();
        tick();
        chk("busy_clr", {31'h0, int_busy}, 32'h0);
        status_reg = 16'h0000;

        // Asynchronous reset in the middle of a TX descriptor write
        bus_start(8'h80, 32'hCAFE_F00D, 4'hF, 1'b1);
        tick();
        chk("tx_b0_we", {31'h0, bd_tx_we}, 32'h1);
        chk("tx_b0_dat", {16'h0, bd_dat_o}, 32'hF00D);
        rst = 1'b1;
        #1;
        chk("rst_bd_we", {31'h0, bd_tx_we}, 32'h0);
        chk("rst_bd_dat", {16'h0, bd_dat_o}, 32'h0);
        chk("rst_bd_clk", {24'h0, clock_divider}, 32'h02);
        chk("rst_bd_cmd", {16'h0, cmd_setting_reg}, 32'h0);
        bus_stop();
        rst = 1'b0;
        tick();
        chk("rst_bd_ack", {31'h0, ack}, 32'h0);
        wb_read(8'h4C, rd, "post_rst_clk"); chk("post_rst_clk_val", rd, 32'h02);
        wb_read(8'h00, rd, "post_rst_arg"); chk("post_rst_arg_val", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
